// File: rtl/semis_dac_pkg.sv
// Shared types and defaults for the sigma-delta DAC and its input buffer.
package semis_dac_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_OSR_LOG2 = 4;
  localparam int FIFO_DEPTH   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dac_state_e;

endpackage

// File: rtl/semis_sample_fifo.sv
// Two-entry sample buffer with a registered occupancy count.
// Pushes when full and pops when empty are ignored.
module semis_sample_fifo
  import semis_dac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  // Next-state for storage, pointers and count; push+pop keeps count and order.
  always_comb begin
    do_push  = push && (count_q != FULL_COUNT);
    do_pop   = pop && (count_q != 2'd0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(do_push) - 2'(do_pop);
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/semis_sd_dac.sv
// First-order sigma-delta DAC: buffered samples in, registered 1-bit
// pulse-density stream out. Each sample is held for 2^OSR_LOG2 cycles and the
// accumulator is never cleared between samples so residual error carries over.
module semis_sd_dac
  import semis_dac_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int OSR_LOG2 = DEF_OSR_LOG2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             dac_out,
  output logic             underrun,
  output logic             busy
);

  localparam logic [OSR_LOG2-1:0] CNT_MAX = {OSR_LOG2{1'b1}};

  dac_state_e          state_q, state_d;
  logic [WIDTH-1:0]    cur_q, cur_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [OSR_LOG2-1:0] cnt_q, cnt_d;
  logic                dac_q, dac_d;
  logic                underrun_q, underrun_d;
  logic [WIDTH:0]      sum;

  logic                fifo_rst_n;
  logic                fifo_push;
  logic                fifo_pop;
  logic [WIDTH-1:0]    fifo_head;
  logic [1:0]          fifo_count;
  logic                fifo_empty;

  // Disabling the block flushes the buffer exactly like a reset does.
  assign fifo_rst_n = rst_n && ena;
  assign in_ready   = (fifo_count != 2'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == 2'd0);
  assign fifo_push  = in_valid && in_ready;

  semis_sample_fifo #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (fifo_rst_n),
    .push     (fifo_push),
    .push_data(in_data),
    .pop      (fifo_pop),
    .head_data(fifo_head),
    .count    (fifo_count)
  );

  // Sequencing: IDLE waits for the first sample, RUN accumulates every cycle
  // and swaps in the next sample only on the last cycle of the period.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    dac_d      = dac_q;
    underrun_d = 1'b0;
    fifo_pop   = 1'b0;
    sum        = {1'b0, acc_q} + {1'b0, cur_q};
    case (state_q)
      IDLE: begin
        dac_d = 1'b0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_head;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d = sum[WIDTH-1:0];
        dac_d = sum[WIDTH];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_MAX) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cur_d    = fifo_head;
          end else begin
            underrun_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registers; reset and disable win over every other event on the edge.
  always_ff @(posedge clk) begin
    if (!rst_n || !ena) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      dac_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      dac_q      <= dac_d;
      underrun_q <= underrun_d;
    end
  end

  assign dac_out  = dac_q;
  assign underrun = underrun_q;
  assign busy     = (state_q == RUN);

endmodule
